// File: rtl/duty_meas_sched.sv
// Round-robin scheduler sharing one duty finder across NUM_CH PWM inputs; each
// channel's duty (or a timeout verdict) is latched into a per-channel slot.
module duty_meas_sched #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 10,
   parameter int TIMEOUT = 2048
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en_i,
   input  logic [NUM_CH-1:0]         pwm_in_i,
   output logic                      meas_pwm_o,
   input  logic                      meas_rdy_i,
   input  logic [CNT_W-1:0]          meas_duty_i,
   output logic [$clog2(NUM_CH)-1:0] cur_ch_o,
   output logic                      busy_o,
   output logic [NUM_CH*CNT_W-1:0]   duty_all_o,
   output logic [NUM_CH-1:0]         valid_o,
   output logic [NUM_CH-1:0]         stuck_o,
   output logic                      sweep_done_o
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int TMO_W = $clog2(TIMEOUT);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SWITCH = 3'd1,
      S_ARM    = 3'd2,
      S_MEAS   = 3'd3,
      S_STORE  = 3'd4
   } state_t;

   state_t                         state_q, state_d;
   logic [CH_W-1:0]                cur_ch_q, cur_ch_d;
   logic                           sw_cnt_q, sw_cnt_d;
   logic [TMO_W-1:0]               tmo_cnt_q, tmo_cnt_d;
   logic                           first_q, first_d;
   logic [CNT_W-1:0]               cap_duty_q, cap_duty_d;
   logic                           cap_stuck_q, cap_stuck_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   duty_q, duty_d;
   logic [NUM_CH-1:0]              valid_q, valid_d;
   logic [NUM_CH-1:0]              stuck_q, stuck_d;
   logic                           sweep_done_q, sweep_done_d;
   logic                           busy_q, busy_d;
   logic                           pwm_sel_s;
   logic                           tmo_hit_s;

   assign pwm_sel_s = pwm_in_i[cur_ch_q];
   assign tmo_hit_s = (tmo_cnt_q == TMO_LAST);

   // The finder only ever sees the owned channel, and only while measuring.
   assign meas_pwm_o   = (state_q == S_MEAS) & pwm_sel_s;
   assign cur_ch_o     = cur_ch_q;
   assign busy_o       = busy_q;
   assign duty_all_o   = duty_q;
   assign valid_o      = valid_q;
   assign stuck_o      = stuck_q;
   assign sweep_done_o = sweep_done_q;

   // Next-state and capture logic of the channel scheduler.
   always_comb begin
      state_d      = state_q;
      cur_ch_d     = cur_ch_q;
      sw_cnt_d     = sw_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      first_d      = first_q;
      cap_duty_d   = cap_duty_q;
      cap_stuck_d  = cap_stuck_q;
      duty_d       = duty_q;
      valid_d      = valid_q;
      stuck_d      = stuck_q;
      sweep_done_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (en_i) begin
               state_d  = S_SWITCH;
               cur_ch_d = '0;
               sw_cnt_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SWITCH: begin
            if (sw_cnt_q) begin
               state_d   = S_ARM;
               sw_cnt_d  = 1'b0;
               tmo_cnt_d = '0;
            end else begin
               sw_cnt_d = 1'b1;
            end
         end
         S_ARM: begin
            // A channel that never goes low ends here as stuck-high.
            if (tmo_hit_s) begin
               state_d     = S_STORE;
               cap_duty_d  = {CNT_W{pwm_sel_s}};
               cap_stuck_d = 1'b1;
            end else if (!pwm_sel_s) begin
               state_d   = S_MEAS;
               first_d   = 1'b1;
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         S_MEAS: begin
            first_d = 1'b0;
            // A finder capture beats a simultaneous timeout.
            if (meas_rdy_i && !first_q) begin
               state_d     = S_STORE;
               cap_duty_d  = meas_duty_i;
               cap_stuck_d = 1'b0;
            end else if (tmo_hit_s) begin
               state_d     = S_STORE;
               cap_duty_d  = {CNT_W{pwm_sel_s}};
               cap_stuck_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         S_STORE: begin
            duty_d[cur_ch_q]  = cap_duty_q;
            valid_d[cur_ch_q] = 1'b1;
            stuck_d[cur_ch_q] = cap_stuck_q;
            sw_cnt_d          = 1'b0;
            if (cur_ch_q == LAST_CH) begin
               sweep_done_d = 1'b1;
               cur_ch_d     = '0;
               state_d      = en_i ? S_SWITCH : S_IDLE;
            end else begin
               cur_ch_d = cur_ch_q + CH_W'(1);
               state_d  = S_SWITCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and result registers; reset discards any measurement in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cur_ch_q     <= '0;
         sw_cnt_q     <= 1'b0;
         tmo_cnt_q    <= '0;
         first_q      <= 1'b0;
         cap_duty_q   <= '0;
         cap_stuck_q  <= 1'b0;
         duty_q       <= '0;
         valid_q      <= '0;
         stuck_q      <= '0;
         sweep_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_ch_q     <= cur_ch_d;
         sw_cnt_q     <= sw_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         first_q      <= first_d;
         cap_duty_q   <= cap_duty_d;
         cap_stuck_q  <= cap_stuck_d;
         duty_q       <= duty_d;
         valid_q      <= valid_d;
         stuck_q      <= stuck_d;
         sweep_done_q <= sweep_done_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_duty_meas_sched.sv
// Bench for duty_meas_sched: PWM generators plus a simple duty finder drive the
// scheduler; latched results are compared with duties derived from each config.
module tb_duty_meas_sched;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 10;
   localparam int TIMEOUT = 2048;
   localparam int CH_W    = $clog2(NUM_CH);
   localparam int BUDGET  = 30000;

   logic                    clk;
   logic                    rst_n;
   logic                    en;
   logic [NUM_CH-1:0]       pwm_in;
   logic                    meas_pwm;
   logic                    meas_rdy;
   logic [CNT_W-1:0]        meas_duty;
   logic [CH_W-1:0]         cur_ch;
   logic                    busy;
   logic [NUM_CH*CNT_W-1:0] duty_all;
   logic [NUM_CH-1:0]       valid;
   logic [NUM_CH-1:0]       stuck;
   logic                    sweep_done;

   int n_tests;
   int n_fail;

   duty_meas_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en),
      .pwm_in_i     (pwm_in),
      .meas_pwm_o   (meas_pwm),
      .meas_rdy_i   (meas_rdy),
      .meas_duty_i  (meas_duty),
      .cur_ch_o     (cur_ch),
      .busy_o       (busy),
      .duty_all_o   (duty_all),
      .valid_o      (valid),
      .stuck_o      (stuck),
      .sweep_done_o (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Channel configuration: high cycles, period, phase to load.
   int c_hi [NUM_CH];
   int c_per[NUM_CH];
   int ld_ph[NUM_CH];
   int ld_seq;
   int ld_seen;
   int phase[NUM_CH];

   always @(negedge clk) begin
      if (ld_seq != ld_seen) begin
         ld_seen <= ld_seq;
         for (int k = 0; k < NUM_CH; k++) phase[k] <= ld_ph[k];
      end else begin
         for (int k = 0; k < NUM_CH; k++)
            phase[k] <= (phase[k] + 1 >= c_per[k]) ? 0 : phase[k] + 1;
      end
   end

   always_comb begin
      pwm_in = '0;
      for (int k = 0; k < NUM_CH; k++) pwm_in[k] = (phase[k] < c_hi[k]);
   end

   // Shared finder: counts the high run, pulses rdy with the count on the fall.
   logic [CNT_W-1:0] f_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_cnt     <= '0;
         meas_rdy  <= 1'b0;
         meas_duty <= '0;
      end else if (meas_pwm) begin
         f_cnt    <= f_cnt + 1'b1;
         meas_rdy <= 1'b0;
      end else begin
         meas_rdy <= (f_cnt != '0);
         if (f_cnt != '0) meas_duty <= f_cnt;
         f_cnt <= '0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: what one measurement of channel k must yield.
   function automatic int exp_duty(input int k);
      if (c_hi[k] == 0) return 0;
      if (c_hi[k] >= c_per[k]) return (1 << CNT_W) - 1;
      return c_hi[k];
   endfunction

   function automatic bit exp_stuck(input int k);
      return (c_hi[k] == 0) || (c_hi[k] >= c_per[k]);
   endfunction

   task automatic set_ch(input int k, input int h, input int p, input int ph);
      c_hi[k]  = h;
      c_per[k] = p;
      ld_ph[k] = ph % p;
   endtask

   task automatic commit();
      ld_seq++;
   endtask

   // Slots may only change for the channel that owned the scheduler before the edge.
   bit                      mon_en;
   logic [NUM_CH*CNT_W-1:0] prev_duty;
   logic [CH_W-1:0]         prev_cur;
   int                      sd_cnt;
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < NUM_CH; k++)
            if (duty_all[k*CNT_W +: CNT_W] !== prev_duty[k*CNT_W +: CNT_W])
               chk("slot_owner", 64'(k), 64'(prev_cur));
      end
      if (sweep_done) sd_cnt <= sd_cnt + 1;
      prev_duty <= duty_all;
      prev_cur  <= cur_ch;
   end

   task automatic wait_sweep(input string tag);
      bit got;
      got = 1'b0;
      for (int n = 0; n < BUDGET && !got; n++) begin
         @(negedge clk);
         got = sweep_done;
      end
      chk({tag, "_done"}, 64'(got), 64'd1);
      if (got) begin
         for (int k = 0; k < NUM_CH; k++) begin
            chk($sformatf("%s_duty%0d", tag, k), 64'(duty_all[k*CNT_W +: CNT_W]), 64'(exp_duty(k)));
            chk($sformatf("%s_stuck%0d", tag, k), 64'(stuck[k]), 64'(exp_stuck(k)));
         end
         chk({tag, "_valid"}, 64'(valid), 64'({NUM_CH{1'b1}}));
         @(negedge clk);
         chk({tag, "_pulse1"}, 64'(sweep_done), 64'd0);
      end
      #1;
   endtask

   task automatic wait_cur(input int ch, input string tag);
      bit got;
      got = 1'b0;
      for (int n = 0; n < BUDGET && !got; n++) begin
         @(negedge clk);
         got = (cur_ch == CH_W'(ch));
      end
      chk(tag, 64'(got), 64'd1);
   endtask

   task automatic rand_cfg();
      for (int k = 0; k < NUM_CH; k++) begin
         int m, p, h;
         m = $urandom_range(0, 9);
         if (m == 0) set_ch(k, 0, 10, 0);
         else if (m == 1) set_ch(k, 10, 10, 0);
         else begin
            p = $urandom_range(4, 200);
            h = $urandom_range(1, p - 1);
            set_ch(k, h, p, $urandom_range(0, p - 1));
         end
      end
      commit();
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_duty"},  64'(duty_all),   64'd0);
      chk({tag, "_valid"}, 64'(valid),      64'd0);
      chk({tag, "_stuck"}, 64'(stuck),      64'd0);
      chk({tag, "_busy"},  64'(busy),       64'd0);
      chk({tag, "_cur"},   64'(cur_ch),     64'd0);
      chk({tag, "_sdone"}, 64'(sweep_done), 64'd0);
      chk({tag, "_mpwm"},  64'(meas_pwm),   64'd0);
   endtask

   initial begin
      int sd_snap;
      bit got;
      n_tests = 0;
      n_fail  = 0;
      ld_seq  = 0;
      ld_seen = 0;
      mon_en  = 1'b0;
      sd_cnt  = 0;
      rst_n   = 1'b0;
      en      = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         set_ch(k, 100 * (k + 1), 1000, $urandom_range(0, 999));
         phase[k] = 0;
      end
      commit();
      repeat (3) @(negedge clk);
      check_reset_outs("rst");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      mon_en = 1'b1;

      // Nominal sweep: ch k high 100*(k+1) of 1000.
      en = 1'b1;
      wait_sweep("nominal");

      // ch2 tied high, others 250/1000.
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 250, 1000, $urandom_range(0, 999));
      set_ch(2, 1000, 1000, 0);
      commit();
      wait_sweep("stuck_hi");

      // ch1 tied low, then recovering at 50 high.
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 250, 1000, $urandom_range(0, 999));
      set_ch(1, 0, 1000, 0);
      commit();
      wait_sweep("stuck_lo");
      set_ch(1, 50, 1000, 0);
      commit();
      wait_sweep("recover");

      // ch1 is mid-high when it takes over from ch0.
      set_ch(0, 900, 1000, 0);
      set_ch(1, 300, 1000, 150);
      set_ch(2, 100, 1000, 0);
      set_ch(3, 500, 1000, 0);
      commit();
      wait_sweep("midhigh");

      for (int r = 0; r < 6; r++) begin
         rand_cfg();
         wait_sweep($sformatf("rand%0d", r));
      end

      // Drop en during ch1: the sweep still completes, then idles.
      rand_cfg();
      wait_cur(1, "en_drop_ch1");
      en = 1'b0;
      wait_sweep("en_drop");
      repeat (2) @(negedge clk);
      chk("idle_after_busy", 64'(busy), 64'd0);
      chk("idle_after_mpwm", 64'(meas_pwm), 64'd0);
      chk("idle_after_cur", 64'(cur_ch), 64'd0);
      sd_snap = sd_cnt;
      repeat (60) @(negedge clk);
      chk("idle_no_sweep", 64'(sd_cnt), 64'(sd_snap));
      chk("idle_still", 64'(busy), 64'd0);

      // Reset while ch2 is being measured.
      set_ch(0, 7, 20, 3);
      set_ch(1, 12, 30, 5);
      set_ch(2, 20, 40, 0);
      set_ch(3, 33, 50, 9);
      commit();
      @(negedge clk);
      en = 1'b1;
      wait_cur(2, "rst_ch2");
      repeat (25) @(negedge clk);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_outs("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      got = 1'b0;
      for (int n = 0; n < BUDGET && !got; n++) begin
         @(negedge clk);
         got = (valid != '0);
      end
      chk("restart_seen", 64'(got), 64'd1);
      chk("restart_ch0", 64'(valid), 64'd1);
      mon_en = 1'b1;
      wait_sweep("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
